// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and
// the keyboard command/response bytes used by the host side.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    DONE,
    ERR
  } tx_state_e;

  localparam int PS2_FRAME_EDGES = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins plus a
// falling-edge strobe on the synchronized clock. Idle bus level is high.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clock_i,
  input  logic data_i,
  output logic clock_o,
  output logic data_o,
  output logic clock_fall_o
);

  logic [1:0] clock_sync_q;
  logic [1:0] data_sync_q;
  logic       clock_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clock_sync_q <= 2'b11;
      data_sync_q  <= 2'b11;
      clock_prev_q <= 1'b1;
    end else begin
      clock_sync_q <= {clock_sync_q[0], clock_i};
      data_sync_q  <= {data_sync_q[0], data_i};
      clock_prev_q <= clock_sync_q[1];
    end
  end

  assign clock_o      = clock_sync_q[1];
  assign data_o       = data_sync_q[1];
  assign clock_fall_o = clock_prev_q & ~clock_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock falls and reports ack/nack/timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output tx_state_e  state_dbg
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       EDGE_LAST = 4'(PS2_FRAME_EDGES - 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic [3:0]       edge_q, edge_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             drv_q, drv_d;

  logic clock_s, data_s, clock_fall;

  ps2_line_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .clock_i      (ps2_clock_in),
    .data_i       (ps2_data_in),
    .clock_o      (clock_s),
    .data_o       (data_s),
    .clock_fall_o (clock_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      parity_q <= 1'b0;
      edge_q   <= '0;
      inh_q    <= '0;
      to_q     <= '0;
      drv_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      parity_q <= parity_d;
      edge_q   <= edge_d;
      inh_q    <= inh_d;
      to_q     <= to_d;
      drv_q    <= drv_d;
    end
  end

  // Handshake: a byte is taken on the cycle tx_valid & tx_ready are both high;
  // tx_ready is high only in IDLE, so requests while busy are simply dropped.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    parity_d     = parity_q;
    edge_d       = edge_q;
    inh_d        = inh_q;
    to_d         = to_q;
    drv_d        = drv_q;
    ps2_clock_oe = 1'b0;
    ps2_data_oe  = 1'b0;
    tx_done      = 1'b0;
    tx_error     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          byte_d   = tx_data;
          parity_d = ~^tx_data;
          edge_d   = '0;
          inh_d    = '0;
          to_d     = '0;
          drv_d    = 1'b0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clock_oe = 1'b1;
        if (inh_q == INH_LAST) state_d = REQ;
        else                   inh_d   = inh_q + 1'b1;
      end
      REQ: begin
        ps2_clock_oe = 1'b1;
        ps2_data_oe  = 1'b1;
        to_d         = '0;
        edge_d       = '0;
        drv_d        = 1'b0;
        state_d      = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = ~drv_q;
        to_d        = to_q + 1'b1;
        // The ack fall wins over a timeout landing in the same cycle.
        if (clock_fall && edge_q == EDGE_LAST) begin
          state_d = data_s ? ERR : DONE;
        end else if (to_q == TO_LAST) begin
          state_d = ERR;
        end else if (clock_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q < 4'd8)       drv_d = byte_q[edge_q[2:0]];
          else if (edge_q == 4'd8) drv_d = parity_q;
          else                     drv_d = 1'b1;
        end
      end
      DONE: begin
        tx_done = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        tx_error = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus model, a device that clocks
// the frame in and acks/nacks, plus inhibit, timeout and mid-frame disturbances.
module tb_ps2_host_tx;

  localparam int INHIBIT = 60;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       clock_oe, data_oe;
  ps2_pkg::tx_state_e state_dbg;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic clk_line, dat_line;
  assign clk_line = ~clock_oe & dev_clk;
  assign dat_line = ~data_oe & dev_dat;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_error     (tx_error),
    .busy         (busy),
    .ps2_clock_in (clk_line),
    .ps2_data_in  (dat_line),
    .ps2_clock_oe (clock_oe),
    .ps2_data_oe  (data_oe),
    .state_dbg    (state_dbg)
  );

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_send(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  // Called on the first negedge after accept; returns on the first SHIFT cycle.
  task automatic check_inhibit();
    int good = 0;
    for (int i = 0; i < INHIBIT; i++) begin
      if (clock_oe === 1'b1 && data_oe === 1'b0) good++;
      @(negedge clk);
    end
    check("inhibit_len", good, INHIBIT);
    check("req_oe", {clock_oe, data_oe}, 2'b11);
    @(negedge clk);
    check("start_oe", {clock_oe, data_oe}, 2'b01);
  endtask

  // mode 0 ack, 1 nack, 2 tx_valid injected after fall 3, 3 reset after fall 5
  task automatic dev_frame(input int mode, output logic [9:0] got,
                           output logic [3:0] dpat, output logic [3:0] epat,
                           output logic rdy_after);
    int n = 0;
    got = '0; dpat = '0; epat = '0; rdy_after = 1'b0;
    while (!(clk_line === 1'b1 && dat_line === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dev_start_seen", n < 200, 1'b1);
    if (n >= 200) return;
    wait_cycles(HALF);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      for (int j = 0; j < HALF; j++) begin
        @(negedge clk);
        if (mode == 2 && i == 2) begin
          if (j == 2) begin
            check("ready_midframe", tx_ready, 1'b0);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
          end
          if (j == 6) begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
          end
        end
        if (mode == 3 && i == 4 && j == 8) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("rst_mid_oe", {clock_oe, data_oe}, 2'b00);
          check("rst_mid_busy", busy, 1'b0);
          check("rst_mid_ready", tx_ready, 1'b1);
          dev_clk = 1'b1;
          dev_dat = 1'b1;
          return;
        end
      end
      dev_clk = 1'b1;
      got[i]  = dat_line;
      wait_cycles(HALF);
    end
    if (mode != 1) dev_dat = 1'b0;
    wait_cycles(HALF);
    dev_clk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dpat[k] = tx_done;
      epat[k] = tx_error;
      if (k == 3) rdy_after = tx_ready;
    end
    wait_cycles(HALF - 4);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic run_frame(input string name, input logic [7:0] b,
                           input logic exp_par, input int mode);
    logic [9:0] got;
    logic [3:0] dpat, epat;
    logic       rdy_after;
    logic [7:0] exp_b;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    host_send(b);
    if (mode != 3) exp_q.push_back(b);
    check_inhibit();
    dev_frame(mode, got, dpat, epat, rdy_after);
    wait_cycles(10);
    if (mode == 3) begin
      check({name, "_no_done"}, done_cnt - d0, 0);
      check({name, "_no_err"}, err_cnt - e0, 0);
      check({name, "_oe_idle"}, {clock_oe, data_oe}, 2'b00);
    end else begin
      exp_b = exp_q.pop_front();
      check({name, "_data"}, got[7:0], exp_b);
      check({name, "_parity"}, got[8], exp_par);
      check({name, "_stop"}, got[9], 1'b1);
      check({name, "_done_pat"}, dpat, (mode == 1) ? 4'b0000 : 4'b0100);
      check({name, "_err_pat"}, epat, (mode == 1) ? 4'b0100 : 4'b0000);
      check({name, "_ready_after"}, rdy_after, 1'b1);
      check({name, "_done_cnt"}, done_cnt - d0, (mode == 1) ? 0 : 1);
      check({name, "_err_cnt"}, err_cnt - e0, (mode == 1) ? 1 : 0);
      check({name, "_oe_idle"}, {clock_oe, data_oe}, 2'b00);
    end
  endtask

  initial begin
    int n;
    wait_cycles(3);
    rst = 1'b0;
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_oe", {clock_oe, data_oe}, 2'b00);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    check("rst_state", state_dbg, ps2_pkg::IDLE);
    wait_cycles(5);

    run_frame("ack_ed", ps2_pkg::CMD_SET_LEDS, 1'b1, 0);
    run_frame("ack_00", 8'h00, 1'b1, 0);
    run_frame("nack_f4", ps2_pkg::CMD_ENABLE, 1'b0, 1);
    run_frame("inject_ed", ps2_pkg::CMD_SET_LEDS, 1'b1, 2);
    run_frame("rst_mid", ps2_pkg::CMD_SET_LEDS, 1'b1, 3);
    run_frame("recover_f4", ps2_pkg::CMD_ENABLE, 1'b0, 0);

    // Device never clocks: error must land exactly TIMEOUT cycles after REQ exit.
    host_send(ps2_pkg::CMD_RESET);
    check_inhibit();
    n = 0;
    while (tx_error !== 1'b1 && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_oe", {clock_oe, data_oe}, 2'b00);
    check("timeout_no_done", tx_done, 1'b0);
    @(negedge clk);
    check("timeout_ready_next", tx_ready, 1'b1);
    check("timeout_err_single", tx_error, 1'b0);

    check("never_both", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
